// File: rtl/image_pkg.sv
// Shared constants and the feeder state type for the image sorting engine.
package image_pkg;

  localparam int unsigned PIX_W      = 8;
  localparam int unsigned PIX_AW     = 14;
  localparam int unsigned IMG_AW     = 5;
  localparam int unsigned NUM_IMAGES = 1 << IMG_AW;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_REL,
    WAIT_RDY,
    FLUSH,
    DONE
  } feeder_state_t;

endpackage

// File: rtl/image_feeder_if.sv
// Image memory read port plus the pixel stream towards the controller.
// FEEDER_CHECKSUM_EN adds the per-image pixel checksum signals.
interface image_feeder_if
  import image_pkg::*;
#(
  parameter int unsigned PixW  = PIX_W,
  parameter int unsigned PixAw = PIX_AW,
  parameter int unsigned ImgAw = IMG_AW
);

  logic                   mem_rd;
  logic [ImgAw+PixAw-1:0] mem_addr;
  logic [PixW-1:0]        mem_rdata;
  logic                   ready;
  logic                   pix_valid;
  logic [PixW-1:0]        pix_data;
  logic                   pix_last;
  logic [ImgAw-1:0]       image_index;
`ifdef FEEDER_CHECKSUM_EN
  logic [PixW+PixAw-1:0]  pix_sum;
  logic                   sum_valid;

  modport master (
    output mem_rd, mem_addr, pix_valid, pix_data, pix_last, image_index, pix_sum, sum_valid,
    input  mem_rdata, ready
  );
  modport slave (
    input  mem_rd, mem_addr, pix_valid, pix_data, pix_last, image_index, pix_sum, sum_valid,
    output mem_rdata, ready
  );
`else
  modport master (
    output mem_rd, mem_addr, pix_valid, pix_data, pix_last, image_index,
    input  mem_rdata, ready
  );
  modport slave (
    input  mem_rd, mem_addr, pix_valid, pix_data, pix_last, image_index,
    output mem_rdata, ready
  );
`endif

endinterface

// File: rtl/feeder_addr_cnt.sv
// Pixel and image counters that form the image memory read address.
module feeder_addr_cnt
  import image_pkg::*;
#(
  parameter int unsigned PixAw = PIX_AW,
  parameter int unsigned ImgAw = IMG_AW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             next_img,
  input  logic             clear,
  output logic [PixAw-1:0] pix_cnt,
  output logic [ImgAw-1:0] img_cnt,
  output logic             pix_last,
  output logic             img_last
);

  logic [PixAw-1:0] pix_cnt_q, pix_cnt_d;
  logic [ImgAw-1:0] img_cnt_q, img_cnt_d;

  // Next count: clear beats next-image beats increment.
  always_comb begin
    pix_cnt_d = pix_cnt_q;
    img_cnt_d = img_cnt_q;
    if (clear) begin
      pix_cnt_d = '0;
      img_cnt_d = '0;
    end else if (next_img) begin
      pix_cnt_d = '0;
      img_cnt_d = img_cnt_q + ImgAw'(1);
    end else if (inc) begin
      pix_cnt_d = pix_cnt_q + PixAw'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_cnt_q <= '0;
      img_cnt_q <= '0;
    end else begin
      pix_cnt_q <= pix_cnt_d;
      img_cnt_q <= img_cnt_d;
    end
  end

  assign pix_cnt  = pix_cnt_q;
  assign img_cnt  = img_cnt_q;
  assign pix_last = (pix_cnt_q == '1);
  assign img_last = (img_cnt_q == '1);

endmodule

// File: rtl/image_feeder.sv
// Streams every pixel of every image from image memory to the controller,
// one beat per accepted read, pausing while the controller is busy.
// Optional FEEDER_CHECKSUM_EN adds a per-image running pixel sum.
module image_feeder
  import image_pkg::*;
#(
  parameter int unsigned PixW  = PIX_W,
  parameter int unsigned PixAw = PIX_AW,
  parameter int unsigned ImgAw = IMG_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          done,
  image_feeder_if.master bus
);

  feeder_state_t    state_q, state_d;
  logic             rd;
  logic             inc, next_img, clear;
  logic [PixAw-1:0] pix_cnt;
  logic [ImgAw-1:0] img_cnt;
  logic             pix_last, img_last;

  logic             pix_valid_q;
  logic             pix_last_q;
  logic [ImgAw-1:0] image_index_q;
  logic             done_q;

  feeder_addr_cnt #(
    .PixAw (PixAw),
    .ImgAw (ImgAw)
  ) u_addr_cnt (
    .clk      (clk),
    .reset    (reset),
    .inc      (inc),
    .next_img (next_img),
    .clear    (clear),
    .pix_cnt  (pix_cnt),
    .img_cnt  (img_cnt),
    .pix_last (pix_last),
    .img_last (img_last)
  );

  // Next state, read strobe and counter control.
  always_comb begin
    state_d  = state_q;
    rd       = 1'b0;
    inc      = 1'b0;
    next_img = 1'b0;
    clear    = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = FETCH;
          clear   = 1'b1;
        end
      end
      FETCH: begin
        if (bus.ready) begin
          rd = 1'b1;
          // Pixel counter parks on the last pixel; only next_img/clear wrap it.
          if (pix_last) begin
            state_d = img_last ? FLUSH : WAIT_REL;
          end else begin
            inc = 1'b1;
          end
        end
      end
      WAIT_REL: begin
        if (!bus.ready) state_d = WAIT_RDY;
      end
      WAIT_RDY: begin
        if (bus.ready) begin
          next_img = 1'b1;
          state_d  = FETCH;
        end
      end
      FLUSH:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // State and beat output registers; a beat lags its read by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      pix_valid_q   <= 1'b0;
      pix_last_q    <= 1'b0;
      image_index_q <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pix_valid_q   <= rd;
      pix_last_q    <= rd & pix_last;
      image_index_q <= img_cnt;
      done_q        <= (state_d == DONE);
    end
  end

  assign bus.mem_rd      = rd;
  assign bus.mem_addr    = {img_cnt, pix_cnt};
  assign bus.pix_valid   = pix_valid_q;
  assign bus.pix_data    = bus.mem_rdata;
  assign bus.pix_last    = pix_last_q;
  assign bus.image_index = image_index_q;
  assign done            = done_q;

`ifdef FEEDER_CHECKSUM_EN
  logic [PixW+PixAw-1:0] pix_sum_q, pix_sum_d;
  logic                  sum_first_q;
  logic                  sum_valid_q;

  // Running sum; the first beat of an image restarts it.
  always_comb begin
    pix_sum_d = pix_sum_q;
    if (pix_valid_q) begin
      pix_sum_d = (sum_first_q ? '0 : pix_sum_q) + (PixW + PixAw)'(bus.mem_rdata);
    end
  end

  // Checksum registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_sum_q   <= '0;
      sum_first_q <= 1'b1;
      sum_valid_q <= 1'b0;
    end else begin
      pix_sum_q   <= pix_sum_d;
      sum_valid_q <= pix_valid_q & pix_last_q;
      if (pix_valid_q) sum_first_q <= pix_last_q;
    end
  end

  assign bus.pix_sum   = pix_sum_q;
  assign bus.sum_valid = sum_valid_q;
`endif

endmodule

// File: tb/tb_image_feeder.sv
// Bench for image_feeder, built with reduced image geometry so a full run
// stays short. A background scoreboard checks every cycle against a flat
// address model; the main sequence covers reset, stall, image gap and restart.
module tb_image_feeder;

  localparam int unsigned PW  = 8;
  localparam int unsigned PAW = 8;
  localparam int unsigned IAW = 3;
  localparam int unsigned AW  = PAW + IAW;
  localparam int unsigned NTOT = 1 << AW;
  localparam int unsigned NIMG = 1 << IAW;

  logic clk;
  logic reset;
  logic start;
  logic done;

  image_feeder_if #(.PixW(PW), .PixAw(PAW), .ImgAw(IAW)) bus ();

  image_feeder #(.PixW(PW), .PixAw(PAW), .ImgAw(IAW)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .done  (done),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Image 0 holds mem[a] = a[7:0]; later images are offset so image bits matter.
  function automatic logic [PW-1:0] mem_fn(input logic [AW-1:0] a);
    logic [PW-1:0] img;
    img = PW'(a[AW-1:PAW]);
    return a[PAW-1:0] + img * 8'd37;
  endfunction

  always @(posedge clk) if (bus.mem_rd) bus.mem_rdata <= mem_fn(bus.mem_addr);

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Scoreboard state: next expected read / beat address as flat counters.
  logic [AW-1:0] rd_a, bt_a;
  bit            prev_rd;
  int            gap_ph;   // 0 run, 1 want ready low, 2 want ready high, 3 resume, 4 end, 5 idle
  bit            exp_done;
  int            beats = 0, lasts = 0;
`ifdef FEEDER_CHECKSUM_EN
  logic [PW+PAW-1:0] exp_sum;
  bit                sum_first, prev_beat_last;
`endif

  task automatic monitor();
    bit is_last;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("reset_outputs", {bus.mem_rd, bus.pix_valid, bus.pix_last, done, bus.image_index}, 0);
        rd_a = '0; bt_a = '0; prev_rd = 0; gap_ph = 5; exp_done = 0;
`ifdef FEEDER_CHECKSUM_EN
        exp_sum = '0; sum_first = 1; prev_beat_last = 0;
`endif
      end else begin
        chk("done_level", done, exp_done);
        chk("beat_follows_read", bus.pix_valid, prev_rd);
        if (bus.mem_rd) begin
          chk("read_when_ready", bus.ready, 1);
          chk("read_allowed", (gap_ph == 0 || gap_ph == 3), 1);
          chk("read_addr", bus.mem_addr, rd_a);
        end
        if (gap_ph == 3) chk("resume_read", bus.mem_rd, bus.ready);
        is_last = 0;
        if (bus.pix_valid) begin
          is_last = (bt_a[PAW-1:0] == '1);
          chk("beat_data", bus.pix_data, mem_fn(bt_a));
          chk("beat_index", bus.image_index, bt_a[AW-1:PAW]);
          chk("beat_last", bus.pix_last, is_last);
          beats++;
          if (is_last) lasts++;
        end
`ifdef FEEDER_CHECKSUM_EN
        chk("sum_valid", bus.sum_valid, prev_beat_last);
        if (bus.sum_valid) chk("pix_sum", bus.pix_sum, exp_sum);
        if (bus.pix_valid) begin
          exp_sum   = (sum_first ? '0 : exp_sum) + (PW + PAW)'(mem_fn(bt_a));
          sum_first = is_last;
        end
        prev_beat_last = bus.pix_valid && is_last;
`endif
        if (exp_done && start) begin
          exp_done = 0;
          gap_ph   = 0;
        end
        case (gap_ph)
          1: if (!bus.ready) gap_ph = 2;
          2: if (bus.ready) gap_ph = 3;
          3: gap_ph = 0;
          5: if (start) gap_ph = 0;
          default: ;
        endcase
        if (bus.mem_rd) begin
          if (rd_a == '1) gap_ph = 4;
          else if (rd_a[PAW-1:0] == '1) gap_ph = 1;
          rd_a++;
        end
        if (bus.pix_valid) begin
          if (bt_a == '1) exp_done = 1;
          bt_a++;
        end
        prev_rd = bus.mem_rd;
      end
    end
  endtask

  task automatic run_until_read(input logic [AW-1:0] tgt, input bit rnd, input int budget,
                                input string nm);
    bit found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(posedge clk); #1;
      bus.ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      if (bus.mem_rd && bus.mem_addr == tgt) found = 1;
    end
    chk(nm, found, 1);
  endtask

  typedef struct {
    bit            rst;
    bit            st;
    bit            rdy;
    bit            e_rd;
    bit            e_pv;
    logic [AW-1:0] e_addr;
    logic [PW-1:0] e_data;
  } vec_t;

  vec_t tbl[11];
  int   beats0, lasts0;
  bit   reached;

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 11'd0, 8'd0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 11'd0, 8'd0};  // start ignored in reset
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'd0, 8'd0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'd0, 8'd0};  // stays idle
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 11'd0, 8'd0};  // start sampled
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 11'd0, 8'd0};  // first read
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 11'd0, 8'd0};  // beat delivered though not ready
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 8'd0};  // start ignored in FETCH
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 11'd1, 8'd0};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 11'd2, 8'd1};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 11'd3, 8'd2};

    reset = 1'b0;
    start = 1'b0;
    bus.ready = 1'b0;
    fork
      monitor();
    join_none

    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      reset = tbl[i].rst;
      start = tbl[i].st;
      bus.ready = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d_mem_rd", i), bus.mem_rd, tbl[i].e_rd);
      chk($sformatf("vec%0d_pix_valid", i), bus.pix_valid, tbl[i].e_pv);
      chk($sformatf("vec%0d_done", i), done, 0);
      if (tbl[i].e_rd) chk($sformatf("vec%0d_addr", i), bus.mem_addr, tbl[i].e_addr);
      if (tbl[i].e_pv) chk($sformatf("vec%0d_data", i), bus.pix_data, tbl[i].e_data);
    end
    start = 1'b0;

    // Stall right after the read of pixel 100.
    run_until_read(AW'(100), 1'b0, 200, "reach_pix100");
    @(posedge clk); #1; bus.ready = 1'b0;
    @(negedge clk);
    chk("stall_inflight_valid", bus.pix_valid, 1);
    chk("stall_inflight_data", bus.pix_data, 100);
    repeat (4) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("stall_no_beat", bus.pix_valid, 0);
      chk("stall_no_read", bus.mem_rd, 0);
    end
    @(posedge clk); #1; bus.ready = 1'b1;
    @(negedge clk);
    chk("stall_resume_rd", bus.mem_rd, 1);
    chk("stall_resume_addr", bus.mem_addr, 101);

    // Image boundary: ready held high keeps the feeder waiting.
    run_until_read(AW'(NTOT / NIMG - 1), 1'b0, 300, "reach_img0_end");
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1; bus.ready = 1'b1;
      @(negedge clk);
      if (i == 0) begin
        chk("img0_last_valid", bus.pix_valid, 1);
        chk("img0_last_flag", bus.pix_last, 1);
        chk("img0_last_data", bus.pix_data, 8'hFF);
        chk("img0_last_index", bus.image_index, 0);
      end
      chk("wait_rel_no_read", bus.mem_rd, 0);
    end
    repeat (3) begin
      @(posedge clk); #1; bus.ready = 1'b0;
      @(negedge clk);
      chk("gap_low_no_read", bus.mem_rd, 0);
    end
    run_until_read({3'd1, 8'd0}, 1'b0, 2, "img1_first_read");
    @(posedge clk); #1;
    @(negedge clk);
    chk("img1_first_valid", bus.pix_valid, 1);
    chk("img1_first_index", bus.image_index, 1);

    // Asynchronous reset in image 3.
    run_until_read({3'd3, 8'd200}, 1'b1, 4000, "reach_img3_pix200");
    @(posedge clk); #2;
    chk("pre_reset_valid", bus.pix_valid, 1);
    reset = 1'b0;
    #1;
    chk("async_reset_valid", bus.pix_valid, 0);
    chk("async_reset_done", done, 0);
    chk("async_reset_rd", bus.mem_rd, 0);
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b1; bus.ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("restart_rd", bus.mem_rd, 1);
    chk("restart_addr", bus.mem_addr, 0);

    // Full run with random back-pressure and stray start pulses.
    beats0 = beats;
    lasts0 = lasts;
    reached = 0;
    for (int i = 0; i < 20000 && !reached; i++) begin
      @(posedge clk); #1;
      bus.ready = ($urandom_range(0, 3) != 0);
      start = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      if (done) reached = 1;
    end
    start = 1'b0;
    chk("full_run_done", reached, 1);
    chk("full_run_beats", beats - beats0, NTOT);
    chk("full_run_lasts", lasts - lasts0, NIMG);
    repeat (5) begin
      @(posedge clk); #1; bus.ready = ($urandom_range(0, 1) != 0);
      @(negedge clk);
      chk("done_held", done, 1);
    end
    @(posedge clk); #1; start = 1'b1; bus.ready = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    chk("rerun_rd", bus.mem_rd, 1);
    chk("rerun_addr", bus.mem_addr, 0);
    chk("rerun_done_low", done, 0);
    repeat (20) begin
      @(posedge clk); #1; bus.ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
